// File: rtl/mem_map_router.sv
// Memory-map router: decodes a single outstanding request into one of
// N_REGION address regions, drives a registered region strobe for the
// region's wait latency, then returns a held response. Unmapped or
// misaligned accesses are answered immediately with an error and logged.
module mem_map_router #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int N_REGION = 4,
  parameter logic [N_REGION*ADDR_W-1:0] REGION_BASE =
    {32'h10010024, 32'h7FFFE7FC, 32'h10010000, 32'h00400000},
  parameter logic [N_REGION*ADDR_W-1:0] REGION_SIZE =
    {32'h00000024, 32'h00000800, 32'h00000800, 32'h00001000},
  parameter logic [N_REGION*4-1:0] REGION_LAT = {4'd0, 4'd1, 4'd1, 4'd0}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic                       req_we,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [N_REGION-1:0]        region_sel,
  output logic [ADDR_W-1:0]          region_off,
  output logic                       region_we,
  output logic [DATA_W-1:0]          region_wdata,
  input  logic [N_REGION*DATA_W-1:0] region_rdata,
  output logic [ADDR_W-1:0]          fault_addr,
  output logic [7:0]                 fault_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [N_REGION-1:0] region_sel_q;
  logic [ADDR_W-1:0]   region_off_q;
  logic                region_we_q;
  logic [DATA_W-1:0]   region_wdata_q;
  logic [3:0]          wait_cnt_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;
  logic [ADDR_W-1:0]   fault_addr_q;
  logic [7:0]          fault_cnt_q;

  logic                dec_hit;
  logic [N_REGION-1:0] dec_sel;
  logic [ADDR_W-1:0]   dec_off;
  logic [3:0]          dec_lat;
  logic                dec_fault;
  logic                accept;
  logic                wait_done;
  logic [DATA_W-1:0]   sel_rdata;

  // The upper bound is formed one bit wider so base+size never wraps.
  function automatic logic in_region(input logic [ADDR_W-1:0] a,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] size);
    return (size != '0) && (a >= base) &&
           ({1'b0, a} < ({1'b0, base} + {1'b0, size}));
  endfunction

  // Address decode; scanning from the top index down lets the lowest match win.
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    dec_off = '0;
    dec_lat = '0;
    for (int i = N_REGION - 1; i >= 0; i--) begin
      if (in_region(req_addr, REGION_BASE[i*ADDR_W +: ADDR_W],
                    REGION_SIZE[i*ADDR_W +: ADDR_W])) begin
        dec_hit    = 1'b1;
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
        dec_off    = req_addr - REGION_BASE[i*ADDR_W +: ADDR_W];
        dec_lat    = REGION_LAT[i*4 +: 4];
      end
    end
  end

  assign dec_fault = !dec_hit || (req_addr[1:0] != 2'b00);
  assign accept    = req_valid && (state_q == S_IDLE);
  assign wait_done = (state_q == S_WAIT) && (wait_cnt_q == 4'd0);

  // Read-data mux driven by the registered one-hot strobe.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_REGION; i++) begin
      if (region_sel_q[i]) sel_rdata |= region_rdata[i*DATA_W +: DATA_W];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = dec_fault ? S_RESP : S_WAIT;
      S_WAIT:  if (wait_done) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
  end

  // Region strobe, wait counter, response capture and fault log.
  always_ff @(posedge clk) begin
    if (rst) begin
      region_sel_q   <= '0;
      region_off_q   <= '0;
      region_we_q    <= 1'b0;
      region_wdata_q <= '0;
      wait_cnt_q     <= '0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      fault_addr_q   <= '0;
      fault_cnt_q    <= '0;
    end else if (accept) begin
      if (dec_fault) begin
        rsp_err_q    <= 1'b1;
        rsp_rdata_q  <= '0;
        fault_addr_q <= req_addr;
        if (fault_cnt_q != 8'hFF) fault_cnt_q <= fault_cnt_q + 8'd1;
      end else begin
        region_sel_q   <= dec_sel;
        region_off_q   <= dec_off;
        region_we_q    <= req_we;
        region_wdata_q <= req_wdata;
        wait_cnt_q     <= dec_lat;
        rsp_err_q      <= 1'b0;
      end
    end else if (wait_done) begin
      rsp_rdata_q  <= region_we_q ? '0 : sel_rdata;
      region_sel_q <= '0;
      region_we_q  <= 1'b0;
    end else if (state_q == S_WAIT) begin
      wait_cnt_q <= wait_cnt_q - 4'd1;
    end
  end

  assign region_sel   = region_sel_q;
  assign region_off   = region_off_q;
  assign region_we    = region_we_q;
  assign region_wdata = region_wdata_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign fault_addr   = fault_addr_q;
  assign fault_cnt    = fault_cnt_q;

endmodule

// File: tb/tb_mem_map_router.sv
// Scoreboard bench for mem_map_router with the default region map.
module tb_mem_map_router;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int N_REGION = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       req_valid;
  logic                       req_ready;
  logic [ADDR_W-1:0]          req_addr;
  logic                       req_we;
  logic [DATA_W-1:0]          req_wdata;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [DATA_W-1:0]          rsp_rdata;
  logic                       rsp_err;
  logic [N_REGION-1:0]        region_sel;
  logic [ADDR_W-1:0]          region_off;
  logic                       region_we;
  logic [DATA_W-1:0]          region_wdata;
  logic [N_REGION*DATA_W-1:0] region_rdata;
  logic [ADDR_W-1:0]          fault_addr;
  logic [7:0]                 fault_cnt;

  always #5 clk = ~clk;

  mem_map_router dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .region_sel(region_sel), .region_off(region_off), .region_we(region_we),
    .region_wdata(region_wdata), .region_rdata(region_rdata),
    .fault_addr(fault_addr), .fault_cnt(fault_cnt)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_chk  = 0;
  int          n_pass = 0;
  int          exp_fcnt = 0;
  logic [31:0] exp_faddr = '0;
  logic [31:0] rd [N_REGION];

  // Reference region map (index 0 is the least significant packed entry).
  logic [31:0] m_base [N_REGION] = '{32'h00400000, 32'h10010000, 32'h7FFFE7FC, 32'h10010024};
  logic [31:0] m_size [N_REGION] = '{32'h00001000, 32'h00000800, 32'h00000800, 32'h00000024};
  int          m_lat  [N_REGION] = '{0, 1, 1, 0};

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic model_decode(input logic [31:0] a, output logic hit, output int idx,
                              output logic [31:0] off, output int lat);
    hit = 1'b0; idx = 0; off = '0; lat = 0;
    for (int i = 0; i < N_REGION; i++) begin
      if (!hit && m_size[i] != 0 && a >= m_base[i] &&
          {32'h0, a} < ({32'h0, m_base[i]} + {32'h0, m_size[i]})) begin
        hit = 1'b1; idx = i; off = a - m_base[i]; lat = m_lat[i];
      end
    end
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) check_eq("sb_unexpected_rsp", sb_q.size(), 1);
      else begin
        mon_e = sb_q.pop_front();
        check_eq("rsp_rdata", rsp_rdata, mon_e.rdata);
        check_eq("rsp_err", rsp_err, mon_e.err);
      end
    end
  end

  task automatic run_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                         input int delay, input logic [31:0] fixed);
    logic hit; int idx; logic [31:0] off; int lat; logic fault; int n; exp_t e;
    logic [N_REGION-1:0] esel;
    model_decode(a, hit, idx, off, lat);
    fault = !hit || (a[1:0] != 2'b00);
    for (int i = 0; i < N_REGION; i++) rd[i] = $urandom;
    if (fixed != 0) rd[idx] = fixed;
    for (int i = 0; i < N_REGION; i++) region_rdata[i*32 +: 32] = rd[i];
    e.err   = fault;
    e.rdata = (fault || we) ? 32'h0 : rd[idx];
    esel = '0;
    if (!fault) esel[idx] = 1'b1;
    n = fault ? 0 : lat + 1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
    @(negedge clk);
    check_eq("req_ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb_q.push_back(e);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      check_eq("region_sel", region_sel, esel);
      check_eq("rsp_valid_early", rsp_valid, 0);
      if (j == 0) begin
        check_eq("region_off", region_off, off);
        check_eq("region_we", region_we, we);
        if (we) check_eq("region_wdata", region_wdata, wd);
      end
    end
    @(negedge clk);
    check_eq("rsp_valid_on_time", rsp_valid, 1);
    check_eq("region_sel_resp", region_sel, 0);
    if (fault) begin
      exp_fcnt  = (exp_fcnt < 255) ? exp_fcnt + 1 : 255;
      exp_faddr = a;
    end
    check_eq("fault_cnt", fault_cnt, exp_fcnt);
    check_eq("fault_addr", fault_addr, exp_faddr);
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      check_eq("hold_rsp_valid", rsp_valid, 1);
      check_eq("hold_req_ready", req_ready, 0);
      check_eq("hold_rsp_rdata", rsp_rdata, e.rdata);
      check_eq("hold_rsp_err", rsp_err, e.err);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check_eq("rsp_valid_after", rsp_valid, 0);
    check_eq("req_ready_after", req_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0;
    rsp_ready = 1'b0; region_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_req_ready", req_ready, 1);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_region_sel", region_sel, 0);
    check_eq("rst_region_we", region_we, 0);
    check_eq("rst_fault_addr", fault_addr, 0);
    check_eq("rst_fault_cnt", fault_cnt, 0);

    run_req(32'h00400004, 1'b0, 32'h0, 0, 32'hDEADBEEF);
    run_req(32'h10010010, 1'b1, 32'h55, 0, 32'h0);
    run_req(32'h20000000, 1'b0, 32'h0, 0, 32'h0);
    run_req(32'h10010026, 1'b0, 32'h0, 0, 32'h0);
    run_req(32'h10010024, 1'b0, 32'h0, 0, 32'h0);
    run_req(32'h7FFFE800, 1'b0, 32'h0, 5, 32'h0);
    run_req(32'h7FFFEFF8, 1'b1, 32'hA5A5A5A5, 2, 32'h0);
    run_req(32'h7FFFEFFC, 1'b0, 32'h0, 0, 32'h0);
    run_req(32'h00400FFC, 1'b0, 32'h0, 1, 32'h0);
    run_req(32'h00401000, 1'b0, 32'h0, 0, 32'h0);
    run_req(32'h7FFFE7F8, 1'b0, 32'h0, 0, 32'h0);

    // Reset while the router is waiting on region 1.
    for (int i = 0; i < N_REGION; i++) region_rdata[i*32 +: 32] = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h10010000; req_we = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_eq("wait_region_sel", region_sel, 4'b0010);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstwait_region_sel", region_sel, 0);
    check_eq("rstwait_rsp_valid", rsp_valid, 0);
    check_eq("rstwait_req_ready", req_ready, 1);
    check_eq("rstwait_fault_cnt", fault_cnt, 0);
    exp_fcnt = 0; exp_faddr = '0;

    run_req(32'h10010100, 1'b0, 32'h0, 0, 32'h0);
    run_req(32'h00400010, 1'b1, 32'h12345678, 0, 32'h0);

    for (int k = 0; k < 300; k++) run_req(32'h30000000 + k * 4, 1'b0, 32'h0, 0, 32'h0);
    check_eq("fault_cnt_saturated", fault_cnt, 255);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
